// File: rtl/weight_stream_pkg.sv
// weight_stream_gen shared types
// FSM state and counter-width helper
package weight_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } ws_state_e;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_stream_mem.sv
// weight_stream_gen storage
// 1W/1R RAM, registered read, write-first
module weight_stream_mem
  import weight_stream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // write port; read forwards a same-cycle write
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) begin
      if (i_we && (i_waddr == i_raddr))
        r_rdata <= i_wdata;
      else
        r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/weight_stream_gen.sv
// weight_stream_gen top
// replays a stored weight set NUM_REPS times
module weight_stream_gen
  import weight_stream_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4096,
  parameter int NUM_REPS = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_waddr,
  input  logic [WIDTH-1:0]         cfg_wdata,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         m_axis_weights_tdata,
  output logic                     m_axis_weights_tvalid,
  input  logic                     m_axis_weights_tready,
  output logic                     m_axis_weights_tlast
);

  localparam int AW = cnt_w(DEPTH);
  localparam int RW = cnt_w(NUM_REPS + 1);

  ws_state_e        r_state, w_state_nx;
  logic [AW-1:0]    r_addr, w_addr_cur;
  logic [RW-1:0]    r_rep, w_rep_cur;
  logic             r_rvalid, r_rlast;
  logic [WIDTH-1:0] w_rdata;
  logic             r_ov, r_ol, r_sv, r_sl;
  logic [WIDTH-1:0] r_od, r_sd;
  logic             r_done;
  logic             w_pop, w_issue, w_start;
  logic             w_we, w_wrap, w_last_rd;
  logic             w_final;
  logic [1:0]       w_room;

  assign w_start = (r_state == IDLE) && start
                   && !r_done;
  assign w_we    = cfg_we && (r_state == IDLE);
  assign w_pop   = r_ov && m_axis_weights_tready;

  // entries held after this cycle's pop
  assign w_room = {1'b0, r_ov} + {1'b0, r_sv}
                + {1'b0, r_rvalid}
                - {1'b0, w_pop};

  // counters read as zero when a run starts
  assign w_addr_cur = (r_state == STREAM)
                      ? r_addr : '0;
  assign w_rep_cur  = (r_state == STREAM)
                      ? r_rep : '0;

  assign w_issue = w_start ||
                   ((r_state == STREAM) &&
                    (w_room < 2'd2));
  assign w_wrap    = w_addr_cur == AW'(DEPTH - 1);
  assign w_last_rd = w_wrap &&
                     (w_rep_cur == RW'(NUM_REPS - 1));
  assign w_final   = (r_state == DRAIN) && w_pop
                     && !r_sv && !r_rvalid;

  weight_stream_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (ap_clk),
    .i_we    (w_we),
    .i_waddr (cfg_waddr),
    .i_wdata (cfg_wdata),
    .i_re    (w_issue),
    .i_raddr (w_addr_cur),
    .o_rdata (w_rdata)
  );

  // state register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nx;
  end

  // next-state logic
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:   if (w_start) w_state_nx = STREAM;
      STREAM: if (w_issue && w_last_rd)
                w_state_nx = DRAIN;
      DRAIN:  if (w_final) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // read address and repetition counters
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_addr <= '0;
      r_rep  <= '0;
    end else if (w_issue) begin
      if (w_wrap) begin
        r_addr <= '0;
        r_rep  <= w_rep_cur + RW'(1);
      end else begin
        r_addr <= w_addr_cur + AW'(1);
        r_rep  <= w_rep_cur;
      end
    end
  end

  // tag of the read now at the RAM output
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      r_rvalid <= w_issue;
      r_rlast  <= w_issue && w_wrap;
    end
  end

  // output register plus skid register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ov <= 1'b0;
      r_ol <= 1'b0;
      r_od <= '0;
      r_sv <= 1'b0;
      r_sl <= 1'b0;
      r_sd <= '0;
    end else if (w_pop || !r_ov) begin
      if (r_sv) begin
        r_ov <= 1'b1;
        r_od <= r_sd;
        r_ol <= r_sl;
        r_sv <= r_rvalid;
        r_sd <= w_rdata;
        r_sl <= r_rvalid && r_rlast;
      end else begin
        r_ov <= r_rvalid;
        r_ol <= r_rvalid && r_rlast;
        if (r_rvalid) r_od <= w_rdata;
      end
    end else if (r_rvalid) begin
      r_sv <= 1'b1;
      r_sd <= w_rdata;
      r_sl <= r_rlast;
    end
  end

  // completion pulse
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_done <= 1'b0;
    else           r_done <= w_final;
  end

  assign busy = r_state != IDLE;
  assign done = r_done;
  assign m_axis_weights_tdata  = r_od;
  assign m_axis_weights_tvalid = r_ov;
  assign m_axis_weights_tlast  = r_ol;

endmodule

// File: tb/tb_weight_stream_gen.sv
// weight_stream_gen bench
// small-set vectors plus one full-size run
module tb_weight_stream_gen;

  localparam int D  = 4;
  localparam int R  = 2;
  localparam int DB = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       we, start, busy, done;
  logic [1:0] waddr;
  logic [7:0] wdata, tdata;
  logic       tvalid, tready, tlast;

  logic        b_we, b_start, b_busy, b_done;
  logic [11:0] b_waddr;
  logic [7:0]  b_wdata, b_tdata;
  logic        b_tvalid, b_tready, b_tlast;

  always #5 clk = ~clk;

  weight_stream_gen #(
    .WIDTH(8), .DEPTH(D), .NUM_REPS(R)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .cfg_we(we), .cfg_waddr(waddr),
    .cfg_wdata(wdata), .start(start),
    .busy(busy), .done(done),
    .m_axis_weights_tdata(tdata),
    .m_axis_weights_tvalid(tvalid),
    .m_axis_weights_tready(tready),
    .m_axis_weights_tlast(tlast)
  );

  weight_stream_gen #(
    .WIDTH(8), .DEPTH(DB), .NUM_REPS(1)
  ) dut_big (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .cfg_we(b_we), .cfg_waddr(b_waddr),
    .cfg_wdata(b_wdata), .start(b_start),
    .busy(b_busy), .done(b_done),
    .m_axis_weights_tdata(b_tdata),
    .m_axis_weights_tvalid(b_tvalid),
    .m_axis_weights_tready(b_tready),
    .m_axis_weights_tlast(b_tlast)
  );

  typedef struct {
    logic       rdy;
    logic       busy;
    logic       done;
    logic       vld;
    logic [7:0] data;
    logic       last;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] wset [4];
  vec_t       tbl [11];
  logic [7:0] gd [$];
  logic       gl [$];
  int ndone, stab_bad, done_cyc;

  task automatic chk(input string nm,
                     input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one run; mode 1 stalls, 2 writes, 3 restarts,
  // 4 writes in the start cycle
  task automatic stream(input int mode,
                        input int stall_at);
    logic       pst, pl;
    logic [7:0] pd;
    gd.delete();
    gl.delete();
    ndone = 0;
    stab_bad = 0;
    done_cyc = -1;
    pst = 1'b0;
    pd = '0;
    pl = 1'b0;
    start = 1'b1;
    tready = 1'b1;
    if (mode == 4) begin
      we = 1'b1;
      waddr = 2'd0;
      wdata = 8'h55;
    end
    tick();
    start = 1'b0;
    we = 1'b0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      tready = 1'b1;
      if (mode == 1) begin
        if (cyc >= 2 && cyc <= 5)
          tready = (cyc % 2 == 0);
        if (cyc >= stall_at && cyc < stall_at + 5)
          tready = 1'b0;
      end
      if (mode == 2 && cyc == 3) begin
        we = 1'b1;
        waddr = 2'd0;
        wdata = 8'hFF;
      end
      if (mode == 3 && cyc == 4) start = 1'b1;
      @(negedge clk);
      if (pst && (!tvalid || tdata != pd ||
                  tlast != pl))
        stab_bad++;
      pst = tvalid && !tready;
      pd = tdata;
      pl = tlast;
      if (tvalid && tready) begin
        gd.push_back(tdata);
        gl.push_back(tlast);
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      tick();
      start = 1'b0;
      we = 1'b0;
      if (done_cyc >= 0 && cyc >= done_cyc + 3)
        break;
    end
    chk("run_done_seen", int'(done_cyc >= 0), 1);
  endtask

  task automatic check_run(input string tag,
                           input logic [7:0] e0);
    logic [7:0] ex;
    chk({tag, "_beats"}, gd.size(), 8);
    for (int i = 0; i < 8 && i < gd.size(); i++) begin
      ex = (i % 4 == 0) ? e0 : wset[i % 4];
      chk($sformatf("%s_data%0d", tag, i),
          int'(gd[i]), int'(ex));
      chk($sformatf("%s_last%0d", tag, i),
          int'(gl[i]), int'(i % 4 == 3));
    end
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_stable"}, stab_bad, 0);
  endtask

  initial begin
    int n, cnt, derr, nlast, lidx, dcyc;
    wset[0] = 8'h11;
    wset[1] = 8'h22;
    wset[2] = 8'h33;
    wset[3] = 8'h44;
    for (int i = 0; i < 11; i++) begin
      tbl[i].rdy  = 1'b1;
      tbl[i].busy = (i >= 1 && i <= 9);
      tbl[i].done = (i == 10);
      tbl[i].vld  = (i >= 2 && i <= 9);
      tbl[i].data = (i >= 2 && i <= 9)
                    ? wset[(i - 2) % 4] : 8'h00;
      tbl[i].last = (i >= 2 && i <= 9) &&
                    ((i - 2) % 4 == 3);
    end

    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    start = 1'b0; tready = 1'b1;
    b_we = 1'b0; b_waddr = '0; b_wdata = '0;
    b_start = 1'b0; b_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", int'(tvalid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_tlast", int'(tlast), 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      we = 1'b1;
      waddr = 2'(i);
      wdata = wset[i];
      tick();
    end
    we = 1'b0;
    tick();

    // cycle table: row i is cycle i after start
    for (int i = 0; i < 11; i++) begin
      start = (i == 0);
      tready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl_busy%0d", i),
          int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl_done%0d", i),
          int'(done), int'(tbl[i].done));
      chk($sformatf("tbl_vld%0d", i),
          int'(tvalid), int'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk($sformatf("tbl_data%0d", i),
            int'(tdata), int'(tbl[i].data));
        chk($sformatf("tbl_last%0d", i),
            int'(tlast), int'(tbl[i].last));
      end
      tick();
    end
    start = 1'b0;
    tick();

    stream(1, $urandom_range(6, 9));
    check_run("stall", 8'h11);
    stream(2, 0);
    check_run("wr_busy", 8'h11);
    stream(0, 0);
    check_run("after_wr", 8'h11);
    chk("after_wr_done_cyc", done_cyc, 10);
    stream(3, 0);
    check_run("restart", 8'h11);

    start = 1'b1;
    tready = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (tvalid && tready) n++;
      tick();
    end
    chk("rst_mid_beats", n, 3);
    rst_n = 1'b0;
    #2;
    chk("rst_mid_tvalid", int'(tvalid), 0);
    chk("rst_mid_tdata", int'(tdata), 0);
    chk("rst_mid_tlast", int'(tlast), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    stream(0, 0);
    check_run("post_rst", 8'h11);

    stream(4, 0);
    check_run("wr_start", 8'h55);

    for (int i = 0; i < DB; i++) begin
      b_we = 1'b1;
      b_waddr = 12'(i);
      b_wdata = 8'((i & 255) ^ 'h5A);
      tick();
    end
    b_we = 1'b0;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 0; derr = 0; nlast = 0;
    lidx = -1; dcyc = -1;
    for (int c = 1; c < 4200; c++) begin
      @(negedge clk);
      if (b_tvalid && b_tready) begin
        if (int'(b_tdata) != ((cnt & 255) ^ 'h5A))
          derr++;
        cnt++;
        if (b_tlast) begin
          nlast++;
          lidx = cnt;
        end
      end
      if (b_done && dcyc < 0) dcyc = c;
      tick();
      if (dcyc >= 0 && c >= dcyc + 2) break;
    end
    chk("big_beats", cnt, DB);
    chk("big_data_err", derr, 0);
    chk("big_nlast", nlast, 1);
    chk("big_last_idx", lidx, DB);
    chk("big_done_cyc", dcyc, DB + 2);
    @(negedge clk);
    chk("big_idle_vld", int'(b_tvalid), 0);
    chk("big_idle_busy", int'(b_busy), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
